// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared widths, product bus type and saturating add for the CU drain
package cu_pkg;

  localparam int PROD_W = 16;
  localparam int NUM_PE = 9;
  localparam int ACC_W  = 32;
  localparam int Q_W    = 8;
  localparam int TRIP_W = PROD_W + 2;
  localparam int TOT_W  = PROD_W + 4;

  typedef logic [NUM_PE*PROD_W-1:0] prod_bus_t;

  // Returns {saturated, sum}; sum clamps to all-ones when the add carries out.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [TOT_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + (ACC_W+1)'(b);
    if (s[ACC_W]) s = {1'b1, {ACC_W{1'b1}}};
    return s;
  endfunction

endpackage

// File: rtl/cu_add_tree.sv
// rtl/cu_add_tree.sv - beat capture plus two-stage adder tree reducing nine products to one total
module cu_add_tree
  import cu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             hold_i,
  input  logic             valid_i,
  input  logic             last_i,
  input  prod_bus_t        data_i,
  output logic             valid_o,
  output logic             last_o,
  output logic [TOT_W-1:0] total_o
);

  prod_bus_t         beat_q;
  logic              bv_q, bl_q;
  logic [TRIP_W-1:0] trip_d [3];
  logic [TRIP_W-1:0] trip_q [3];
  logic              v1_q, l1_q;
  logic [TOT_W-1:0]  tot_d, tot_q;
  logic              v2_q, l2_q;

  always_comb begin
    for (int j = 0; j < 3; j++) begin
      trip_d[j] = TRIP_W'(beat_q[(3*j)*PROD_W +: PROD_W])
                + TRIP_W'(beat_q[(3*j+1)*PROD_W +: PROD_W])
                + TRIP_W'(beat_q[(3*j+2)*PROD_W +: PROD_W]);
    end
    tot_d = TOT_W'(trip_q[0]) + TOT_W'(trip_q[1]) + TOT_W'(trip_q[2]);
  end

  // Every stage freezes together on hold so no beat is dropped or duplicated.
  always_ff @(posedge clk) begin
    if (rst) begin
      bv_q <= 1'b0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else if (!hold_i) begin
      bv_q   <= valid_i;
      bl_q   <= last_i;
      beat_q <= data_i;
      v1_q   <= bv_q;
      l1_q   <= bl_q;
      trip_q <= trip_d;
      v2_q   <= v1_q;
      l2_q   <= l1_q;
      tot_q  <= tot_d;
    end
  end

  assign valid_o = v2_q;
  assign last_o  = l2_q;
  assign total_o = tot_q;

endmodule

// File: rtl/cu_psum_drain.sv
// rtl/cu_psum_drain.sv - accumulates reduced PE beats per output point and emits raw plus requantized result
module cu_psum_drain
  import cu_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_PE*PROD_W-1:0] pe_out,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  input  logic [4:0]               quant_shift,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_acc,
  output logic [Q_W-1:0]           out_q,
  output logic                     out_ovf
);

  logic             stall;
  logic             s2_valid, s2_last;
  logic [TOT_W-1:0] s2_total;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             first_q, ovf_q, ovf_d;
  logic [ACC_W:0]   sum_sat;
  logic [ACC_W-1:0] shifted;
  logic [Q_W-1:0]   q_d;

  logic             out_valid_q, out_ovf_q;
  logic [ACC_W-1:0] out_acc_q;
  logic [Q_W-1:0]   out_q_q;

  assign stall    = out_valid_q && !out_ready;
  assign in_ready = !stall;

  cu_add_tree u_tree (
    .clk     (clk),
    .rst     (rst),
    .hold_i  (stall),
    .valid_i (in_valid),
    .last_i  (in_last),
    .data_i  (pe_out),
    .valid_o (s2_valid),
    .last_o  (s2_last),
    .total_o (s2_total)
  );

  always_comb begin
    sum_sat = sat_add(first_q ? '0 : acc_q, s2_total);
    acc_d   = sum_sat[ACC_W-1:0];
    ovf_d   = ovf_q | sum_sat[ACC_W];
    shifted = acc_d >> quant_shift;
    q_d     = (|shifted[ACC_W-1:Q_W]) ? {Q_W{1'b1}} : shifted[Q_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      first_q     <= 1'b1;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_q_q     <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      // A new last result on the handshake edge overrides the drop above.
      if (s2_valid && !stall) begin
        if (s2_last) begin
          out_acc_q   <= acc_d;
          out_ovf_q   <= ovf_d;
          out_q_q     <= q_d;
          out_valid_q <= 1'b1;
          first_q     <= 1'b1;
          ovf_q       <= 1'b0;
        end else begin
          acc_q   <= acc_d;
          first_q <= 1'b0;
          ovf_q   <= ovf_d;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_q     = out_q_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_cu_psum_drain.sv
// tb/tb_cu_psum_drain.sv - scoreboard bench for cu_psum_drain with a point-level reference model
module tb_cu_psum_drain;

  logic         clk = 1'b0;
  logic         rst;
  logic [143:0] pe_out;
  logic         in_valid, in_last, in_ready;
  logic [4:0]   quant_shift;
  logic         out_valid, out_ready;
  logic [31:0]  out_acc;
  logic [7:0]   out_q;
  logic         out_ovf;

  cu_psum_drain dut (
    .clk         (clk),
    .rst         (rst),
    .pe_out      (pe_out),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .quant_shift (quant_shift),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_acc     (out_acc),
    .out_q       (out_q),
    .out_ovf     (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] acc;
    logic [7:0]  q;
    logic        ovf;
  } exp_t;

  localparam longint ACC_MAX = 64'h0000_0000_FFFF_FFFF;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  bit   ready_mode = 1'b0;
  bit   ready_fixed = 1'b1;
  int   stall_seen = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [143:0] make_bus(input int kind, input int fill);
    logic [143:0] b;
    logic [15:0]  p;
    b = '0;
    for (int i = 0; i < 9; i++) begin
      case (kind)
        0:       p = 16'(fill);
        1:       p = 16'(i + 1);
        2:       p = 16'($urandom);
        default: p = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'($urandom_range(0, 3));
      endcase
      b[i*16 +: 16] = p;
    end
    return b;
  endfunction

  function automatic longint bus_sum(input logic [143:0] b);
    longint s = 0;
    for (int i = 0; i < 9; i++) s += longint'(b[i*16 +: 16]);
    return s;
  endfunction

  // out_ready is either held at ready_fixed or randomised every cycle.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = ready_mode ? ($urandom_range(0, 3) != 0) : ready_fixed;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got acc=%0d expected no result", out_acc);
        end else begin
          mon_e = sb.pop_front();
          check("out_acc", longint'(out_acc), longint'(mon_e.acc));
          check("out_q", longint'(out_q), longint'(mon_e.q));
          check("out_ovf", longint'(out_ovf), longint'(mon_e.ovf));
        end
      end
    end
  end

  task automatic send_beat(input logic [143:0] bus, input logic last);
    bit ok = 1'b0;
    pe_out   = bus;
    in_valid = 1'b1;
    in_last  = last;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      stall_seen++;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_point(input int nbeats, input int kind, input int fill,
                            input int gap_max, input bit has_last, input bit check_lat);
    longint       acc = 0;
    bit           ovf = 1'b0;
    longint       t;
    longint       sh;
    logic [143:0] bus;
    exp_t         e;
    int           lat;
    for (int b = 0; b < nbeats; b++) begin
      bus = make_bus(kind, fill);
      t = bus_sum(bus);
      if (acc + t > ACC_MAX) begin
        acc = ACC_MAX;
        ovf = 1'b1;
      end else begin
        acc += t;
      end
      if (b == nbeats - 1 && has_last) begin
        sh = acc >> quant_shift;
        e.acc = acc[31:0];
        e.q   = (sh > 255) ? 8'hFF : 8'(sh);
        e.ovf = ovf;
        sb.push_back(e);
      end
      send_beat(bus, (b == nbeats - 1) && has_last);
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    if (check_lat) begin
      lat = 0;
      for (int n = 1; n <= 8; n++) begin
        @(posedge clk);
        #1;
        if (out_valid) begin
          lat = n;
          break;
        end
      end
      check("latency", lat, 3);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    check("drain_pending", sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    pe_out = '0;
    quant_shift = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_acc", out_acc, 0);
    check("rst_out_q", out_q, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    quant_shift = 5'd0;
    send_point(4, 0, 1, 0, 1'b1, 1'b1);
    drain();

    quant_shift = 5'd12;
    send_point(1, 0, 65535, 0, 1'b1, 1'b0);
    drain();

    quant_shift = 5'd0;
    stall_seen = 0;
    repeat (3) send_point(2, 1, 0, 0, 1'b1, 1'b0);
    check("b2b_in_ready_drops", stall_seen, 0);
    drain();

    ready_fixed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_point(1, 0, 3, 0, 1'b1, 1'b0);
    send_point(3, 1, 0, 0, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_out_acc", out_acc, 27);
    end
    fork
      send_point(1, 0, 2, 0, 1'b1, 1'b0);
      begin
        repeat (6) @(posedge clk);
        #1;
        ready_fixed = 1'b1;
      end
    join
    drain();

    quant_shift = 5'd20;
    send_point(7301, 0, 65535, 0, 1'b1, 1'b0);
    send_point(1, 0, 1, 0, 1'b1, 1'b0);
    drain();

    quant_shift = 5'd0;
    send_point(2, 2, 0, 0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_point(1, 0, 2, 0, 1'b1, 1'b0);
    drain();

    ready_mode = 1'b1;
    for (int ph = 0; ph < 4; ph++) begin
      quant_shift = 5'($urandom_range(0, 31));
      for (int p = 0; p < 10; p++) begin
        send_point($urandom_range(1, 6), $urandom_range(0, 3), $urandom_range(0, 65535),
                   2, 1'b1, 1'b0);
      end
      drain();
    end
    ready_mode = 1'b0;
    ready_fixed = 1'b1;
    repeat (4) @(posedge clk);

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
